// File: rtl/hdmi_pio_pkg.sv
// Shared definitions for the HDMI PIO blocks on the lightweight HPS-to-FPGA bridge:
// the Avalon word-address map and the edge-type encodings.
package hdmi_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_input_sync.sv
// WIDTH-wide, SYNC_STAGES-deep flop synchroniser bringing asynchronous inputs into clk.
// All stages reset to 0; sync_out is the last stage.
module pio_input_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], async_in};
  end

  // NOTE: this is a shift chain, not a storage array, so every stage is reset;
  // otherwise DATA could read stale X/1 values straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign sync_out = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/hdmi_pio_status_in.sv
// Avalon-MM input PIO for HDMI status bits: synchronises in_port, captures selected
// edges into write-1-to-clear sticky bits and raises a maskable level irq.
module hdmi_pio_status_in
  import hdmi_pio_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PRIME_W      = $clog2(PRIME_CYCLES + 1);

  logic [WIDTH-1:0]   sync_q;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]   edge_cap_q, edge_cap_d;
  logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
  logic               primed;
  logic [WIDTH-1:0]   edge_raw, edge_det, cap_clr;
  logic               wr_en;
  pio_addr_e          addr;
  logic               unused_wdata;

  pio_input_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (in_port),
    .sync_out (sync_q)
  );

  assign addr         = pio_addr_e'(address);
  assign wr_en        = chipselect && !write_n;
  assign primed       = (prime_cnt_q == PRIME_W'(PRIME_CYCLES));
  assign unused_wdata = ^writedata;

  // Detection stays off until the chain and prev_q hold post-reset samples, so an
  // input already high at reset is not mistaken for a rising edge.
  always_comb begin
    if (EDGE_TYPE == EDGE_FALL) begin
      edge_raw = ~sync_q & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_raw = sync_q ^ prev_q;
    end else begin
      edge_raw = sync_q & ~prev_q;
    end
    edge_det = primed ? edge_raw : '0;
  end

  always_comb begin
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + PRIME_W'(1);
    prev_d      = sync_q;
    irq_mask_d  = (wr_en && addr == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : irq_mask_q;
    cap_clr     = (wr_en && addr == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    // Set after clear: a new edge in the same cycle as its clear keeps the bit.
    edge_cap_d  = (edge_cap_q & ~cap_clr) | edge_det;
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_q <= '0;
      prev_q      <= '0;
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
    end else begin
      prime_cnt_q <= prime_cnt_d;
      prev_q      <= prev_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
    end
  end

  // NOTE: readdata gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      case (addr)
        ADDR_DATA:     readdata[WIDTH-1:0] = sync_q;
        ADDR_RSVD:     readdata            = '0;
        ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
        ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap_q;
      endcase
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_hdmi_pio_status_in.sv
// Bench for hdmi_pio_status_in: three instances (rising/falling/any edge) share one
// stimulus stream and are compared every cycle against a sample-history reference model.
module tb_hdmi_pio_status_in;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd0, rd1, rd2;
  logic         irq0, irq1, irq2;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  hdmi_pio_status_in #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  hdmi_pio_status_in #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  hdmi_pio_status_in #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Reference model: hist[j] is in_port as sampled j+1 edges ago (post-reset only).
  // DATA shows the sample from S-1 edges ago; an edge between the samples taken
  // S+1 and S edges ago is captured at this edge.
  logic [W-1:0] hist [S+1];
  int           hcnt;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [3];

  function automatic logic [W-1:0] det_of(input int kind);
    logic [W-1:0] cur, prv;
    if (hcnt < S + 1) return '0;
    cur = hist[S-1];
    prv = hist[S];
    case (kind)
      0:       return cur & ~prv;
      1:       return ~cur & prv;
      default: return cur ^ prv;
    endcase
  endfunction

  function automatic logic [W-1:0] clr_val();
    return (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= S; j++) hist[j] <= '0;
      hcnt   <= 0;
      m_mask <= '0;
      for (int i = 0; i < 3; i++) m_cap[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) m_cap[i] <= (m_cap[i] & ~clr_val()) | det_of(i);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
      hist[0] <= in_port;
      for (int j = 1; j <= S; j++) hist[j] <= hist[j-1];
      hcnt <= (hcnt < S + 1) ? hcnt + 1 : hcnt;
    end
  end

  function automatic logic [31:0] exp_rd(input int dut);
    logic [31:0] v;
    v = '0;
    if (chipselect) begin
      case (address)
        2'd0:    v[W-1:0] = (hcnt >= S) ? hist[S-1] : '0;
        2'd2:    v[W-1:0] = m_mask;
        2'd3:    v[W-1:0] = m_cap[dut];
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] act_rd(input int dut);
    case (dut)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic act_irq(input int dut);
    case (dut)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, all instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("model_rd[%0d]", i), act_rd(i), exp_rd(i));
        check($sformatf("model_irq[%0d]", i), {31'd0, act_irq(i)},
              {31'd0, |(m_cap[i] & m_mask)});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    address    = a;
    writedata  = d;
    write_n    = 1'b0;
    step(1);
    write_n    = 1'b1;
  endtask

  task automatic rdchk(input int dut, input logic [1:0] a, input logic [31:0] exp,
                       input string name);
    chipselect = 1'b1;
    address    = a;
    #1;
    check(name, act_rd(dut), exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 4'hF;
    cmp_en     = 1'b1;
    #23 reset_n = 1'b1;

    // Inputs already high at reset: visible in DATA, no edge captured.
    step(10);
    rdchk(0, 2'd0, 32'hF, "data_after_reset");
    rdchk(0, 2'd3, 32'h0, "rise_cap_after_reset");
    rdchk(2, 2'd3, 32'h0, "any_cap_after_reset");
    check("irq_after_reset", {31'd0, irq0}, 32'd0);

    reset_n = 1'b0;
    in_port = '0;
    step(2);
    reset_n = 1'b1;
    step(10);

    // Capture latency and masking.
    wr(2'd2, 32'h5);
    address = 2'd3;
    in_port = 4'h2;
    step(2);
    rdchk(0, 2'd3, 32'h0, "cap_before_latency");
    step(1);
    rdchk(0, 2'd3, 32'h2, "cap_0x2");
    check("irq_masked_out", {31'd0, irq0}, 32'd0);
    in_port = 4'h3;
    step(3);
    rdchk(0, 2'd3, 32'h3, "cap_0x3");
    check("irq_masked_in", {31'd0, irq0}, 32'd1);

    // Write-1-to-clear.
    wr(2'd3, 32'h1);
    rdchk(0, 2'd3, 32'h2, "clear_bit0");
    check("irq_after_clear", {31'd0, irq0}, 32'd0);
    wr(2'd3, 32'h2);
    rdchk(0, 2'd3, 32'h0, "clear_bit1");

    // Clear and new edge on the same bit in the same cycle: set wins.
    in_port = 4'h2;
    step(4);
    wr(2'd3, 32'hF);
    in_port = 4'h3;
    step(2);
    wr(2'd3, 32'h1);
    rdchk(0, 2'd3, 32'h1, "set_wins");
    check("irq_set_wins", {31'd0, irq0}, 32'd1);

    // Edge-type selection.
    wr(2'd3, 32'hF);
    in_port = 4'h2;
    step(3);
    rdchk(0, 2'd3, 32'h0, "fall_on_rise_dut");
    rdchk(1, 2'd3, 32'h1, "fall_on_fall_dut");
    rdchk(2, 2'd3, 32'h1, "fall_on_any_dut");
    wr(2'd3, 32'hF);
    in_port = 4'h3;
    step(3);
    rdchk(0, 2'd3, 32'h1, "rise_on_rise_dut");
    rdchk(1, 2'd3, 32'h0, "rise_on_fall_dut");
    rdchk(2, 2'd3, 32'h1, "rise_on_any_dut");

    // Writes to DATA and reserved are ignored.
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rdchk(0, 2'd1, 32'h0, "rsvd_reads_0");
    rdchk(0, 2'd2, 32'h5, "mask_unchanged");
    rdchk(0, 2'd0, 32'h3, "data_unchanged");
    rdchk(0, 2'd3, 32'h1, "cap_unchanged");
    chipselect = 1'b0;
    address    = 2'd2;
    #1;
    check("read_no_cs", rd0, 32'h0);

    // Asynchronous reset mid-capture.
    chipselect = 1'b1;
    address    = 2'd3;
    reset_n    = 1'b0;
    #1;
    check("irq_async_reset", {31'd0, irq0}, 32'd0);
    check("cap_async_reset", rd0, 32'h0);
    rdchk(0, 2'd2, 32'h0, "mask_async_reset");
    rdchk(0, 2'd0, 32'h0, "data_async_reset");
    step(2);
    reset_n = 1'b1;

    // Randomised traffic, including occasional resets with inputs high.
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      step(1);
    end
    reset_n = 1'b1;
    write_n = 1'b1;
    step(2);
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/hdmi_pio_status_in.md
# hdmi_pio_status_in

Avalon-MM slave input PIO that lets the HPS read status bits driven by the HDMI fabric logic, the inbound counterpart of the HDMI output PIO that drives control bits toward the fabric. It synchronises the asynchronous `in_port` into `clk`, captures selected edges into sticky bits, and raises a maskable level interrupt to the HPS. It sits on the lightweight HPS-to-FPGA bridge next to the output PIOs.

## Interface
- `WIDTH`, 1 — number of input bits (1..32).
- `EDGE_TYPE`, 0 — 0 rising, 1 falling, 2 any edge.
- `SYNC_STAGES`, 2 — synchroniser depth (2..4).
- Reset `reset_n`, asynchronous, active-low; clock `clk`.
- `clk` in 1 — system clock.
- `reset_n` in 1 — async active-low reset.
- `address` in 2 — word address.
- `chipselect` in 1 — slave select.
- `write_n` in 1 — active-low write strobe.
- `writedata` in 32 — write data; bits above WIDTH ignored.
- `in_port` in WIDTH — asynchronous status inputs from HDMI logic.
- `readdata` out 32 — read data, zero-extended above WIDTH.
- `irq` out 1 — level interrupt, active-high.

## Operation
- Register map: 0 DATA (RO, synchronised `in_port`); 1 reserved (reads 0, writes ignored); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (read; write-1-to-clear per bit).
- Synchroniser: per bit, SYNC_STAGES flops; `sync_q` = last stage.
- Edge detect: `prev_q <= sync_q` each cycle; rising = `sync_q & ~prev_q`, falling = `~sync_q & prev_q`, any = XOR.
- Priming: a counter holds detection off until SYNC_STAGES+1 cycles after reset deassertion, so inputs already high at reset do not capture a rising edge.
- EDGE_CAPTURE bit set on detected edge; cleared only by write with that writedata bit = 1 at address 3.
- Simultaneous clear and new edge on same bit in same cycle: set wins (bit stays 1).
- `irq = |(EDGE_CAPTURE & IRQ_MASK)`, from registers, no extra flop.
- Writes to addresses 0 and 1 have no effect; reads without `chipselect` return 0.
- Reset values: sync chain, `prev_q`, IRQ_MASK, EDGE_CAPTURE all 0; `irq` 0; `readdata` 0.

## Timing
- Zero wait states, read latency 0: `readdata` is combinational from address/chipselect and registers.
- Write takes effect on the `clk` edge where `chipselect && !write_n`; new value readable next cycle.
- Change on `in_port` sampled at edge t: DATA reflects it after edge t+SYNC_STAGES-1; EDGE_CAPTURE and `irq` after edge t+SYNC_STAGES.
- IRQ_MASK write: `irq` updates the cycle after the write edge.
- EDGE_CAPTURE clear: `irq` deasserts the cycle after the write edge unless another unmasked bit remains set.
- Pulses shorter than one `clk` period may be missed; no requirement for them.
- Reset mid-operation: all state returns to reset values asynchronously; priming restarts on deassertion.

## Structure
- Shared package `hdmi_pio_pkg`: address constants (ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3), EDGE_TYPE encodings.
- Sub-module `pio_input_sync`: WIDTH-wide, SYNC_STAGES-deep reset-to-0 synchroniser, reused by future input PIOs.
- Top: priming counter, edge detect, capture/mask registers, read mux, irq.

## Test plan
- Reset with `in_port`=1, WIDTH=1, EDGE_TYPE=0: after 10 cycles DATA reads 1, EDGE_CAPTURE reads 0, `irq`=0.
- WIDTH=4, IRQ_MASK=0x5, `in_port` 0→0x2: EDGE_CAPTURE=0x2 exactly SYNC_STAGES+1 edges later, `irq` stays 0; then 0x2→0x3: EDGE_CAPTURE=0x3, `irq`=1.
- Write 0x1 to address 3 → EDGE_CAPTURE=0x2, `irq`=0 next cycle; write 0x2 → 0x0.
- Clear write on bit 0 in the same cycle a new rising edge on bit 0 is detected → bit 0 reads 1, `irq` stays 1 if masked in.
- EDGE_TYPE=1 then 2: 1→0 captured in both; 0→1 captured only for EDGE_TYPE=2.
- Writes to addresses 0/1 with 0xFFFFFFFF → no register change, reads of address 1 return 0; assert `reset_n` mid-capture → `irq` and all registers 0 immediately.
